// File: rtl/user_cmd_sequencer.sv
// Command sequencer behind a memory-mapped user port: reduces operand channels 1..N
// with SUM/MAX/MIN/XOR and reports the result, status flags and a completion count.
module user_cmd_sequencer #(
    parameter logic [31:0] ID    = 32'h5EC0_0001,
    parameter int          MAX_N = 14
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        user_write,
    input  logic        user_read,
    input  logic [15:0] user_chipselect,
    input  logic [31:0] user_dataout_0,
    input  logic [31:0] user_dataout_1,
    input  logic [31:0] user_dataout_2,
    input  logic [31:0] user_dataout_3,
    input  logic [31:0] user_dataout_4,
    input  logic [31:0] user_dataout_5,
    input  logic [31:0] user_dataout_6,
    input  logic [31:0] user_dataout_7,
    input  logic [31:0] user_dataout_8,
    input  logic [31:0] user_dataout_9,
    input  logic [31:0] user_dataout_10,
    input  logic [31:0] user_dataout_11,
    input  logic [31:0] user_dataout_12,
    input  logic [31:0] user_dataout_13,
    input  logic [31:0] user_dataout_14,
    input  logic [31:0] user_dataout_15,
    output logic [31:0] user_datain_0,
    output logic [31:0] user_datain_1,
    output logic [31:0] user_datain_2,
    output logic [31:0] user_datain_3,
    output logic [31:0] user_datain_4,
    output logic [31:0] user_datain_5,
    output logic [31:0] user_datain_6,
    output logic [31:0] user_datain_7,
    output logic [31:0] user_datain_8,
    output logic [31:0] user_datain_9,
    output logic [31:0] user_datain_10,
    output logic [31:0] user_datain_11,
    output logic [31:0] user_datain_12,
    output logic [31:0] user_datain_13,
    output logic [31:0] user_datain_14,
    output logic [31:0] user_datain_15
);

    // state  | meaning
    // S_IDLE | waiting for a command write on channel 0
    // S_RUN  | folding operand idx into the accumulator
    // S_DONE | publishing accumulator to result, bumping the counter
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_MAX = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [4:0] MAX_N5 = 5'(MAX_N);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  n_q, n_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        coll_q, coll_d;

    logic [31:0] dout [16];
    logic [15:0] op_mask;
    logic [32:0] sum_ext;
    logic [31:0] operand;
    logic [3:0]  cmd_n;
    logic [1:0]  cmd_op;
    logic        busy, cmd_accept, cmd_valid, wr_coll, rd_clear;

    assign dout[0]  = user_dataout_0;
    assign dout[1]  = user_dataout_1;
    assign dout[2]  = user_dataout_2;
    assign dout[3]  = user_dataout_3;
    assign dout[4]  = user_dataout_4;
    assign dout[5]  = user_dataout_5;
    assign dout[6]  = user_dataout_6;
    assign dout[7]  = user_dataout_7;
    assign dout[8]  = user_dataout_8;
    assign dout[9]  = user_dataout_9;
    assign dout[10] = user_dataout_10;
    assign dout[11] = user_dataout_11;
    assign dout[12] = user_dataout_12;
    assign dout[13] = user_dataout_13;
    assign dout[14] = user_dataout_14;
    assign dout[15] = user_dataout_15;

    always_comb begin
        op_mask = '0;
        for (int i = 1; i < 16; i++) begin
            if (i <= MAX_N) op_mask[i] = 1'b1;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign cmd_n      = user_dataout_0[7:4];
    assign cmd_op     = user_dataout_0[1:0];
    assign cmd_accept = user_write && user_chipselect[0] && (state_q == S_IDLE);
    assign cmd_valid  = (cmd_n != 4'd0) && ({1'b0, cmd_n} <= MAX_N5);
    assign wr_coll    = busy && user_write && (user_chipselect[0] || |(user_chipselect & op_mask));
    assign rd_clear   = user_read && user_chipselect[0];
    // Operands are sampled live from the port, so a CPU rewrite mid-run is seen.
    assign operand    = dout[idx_q];
    assign sum_ext    = {1'b0, acc_q} + {1'b0, operand};

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            coll_q   <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_accept && cmd_valid) state_d = S_RUN;
            S_RUN:   if (idx_q == n_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        n_d      = n_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        coll_d   = coll_q;

        // Clear first so a same-edge completion below takes priority.
        if (rd_clear) done_d = 1'b0;
        if (wr_coll)  coll_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    op_d   = cmd_op;
                    ovf_d  = 1'b0;
                    coll_d = 1'b0;
                    if (cmd_valid) begin
                        idx_d = 4'd1;
                        n_d   = cmd_n;
                        acc_d = (cmd_op == OP_MIN) ? 32'hFFFF_FFFF : 32'h0;
                        err_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                idx_d = idx_q + 4'd1;
                case (op_q)
                    OP_SUM: begin
                        acc_d = sum_ext[31:0];
                        ovf_d = ovf_q | sum_ext[32];
                    end
                    OP_MAX:  acc_d = (operand > acc_q) ? operand : acc_q;
                    OP_MIN:  acc_d = (operand < acc_q) ? operand : acc_q;
                    default: acc_d = acc_q ^ operand;
                endcase
            end
            S_DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                cnt_d    = cnt_q + 32'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        user_datain_0  = {16'b0, cnt_q[7:0], 3'b0, coll_q, ovf_q, err_q, done_q, busy};
        user_datain_1  = result_q;
        user_datain_2  = cnt_q;
        user_datain_3  = {28'b0, op_q, 2'b0};
        user_datain_4  = '0;
        user_datain_5  = '0;
        user_datain_6  = '0;
        user_datain_7  = '0;
        user_datain_8  = '0;
        user_datain_9  = '0;
        user_datain_10 = '0;
        user_datain_11 = '0;
        user_datain_12 = '0;
        user_datain_13 = '0;
        user_datain_14 = '0;
        user_datain_15 = ID;
    end

endmodule

// File: tb/tb_user_cmd_sequencer.sv
// Bench for user_cmd_sequencer: directed scenarios plus randomized commands
// compared against an arithmetic reference of each reduction.
module tb_user_cmd_sequencer;

    localparam logic [31:0] ID   = 32'h5EC0_0001;
    localparam int          MAXN = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr, rd;
    logic [15:0] cs;
    logic [31:0] dout [16];
    logic [31:0] din  [16];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt;
    logic [31:0] exp_result;

    always #5 clk = ~clk;

    user_cmd_sequencer #(.ID(ID), .MAX_N(MAXN)) dut (
        .clk_clk(clk), .reset_reset(rst), .user_write(wr), .user_read(rd),
        .user_chipselect(cs),
        .user_dataout_0(dout[0]),   .user_dataout_1(dout[1]),   .user_dataout_2(dout[2]),
        .user_dataout_3(dout[3]),   .user_dataout_4(dout[4]),   .user_dataout_5(dout[5]),
        .user_dataout_6(dout[6]),   .user_dataout_7(dout[7]),   .user_dataout_8(dout[8]),
        .user_dataout_9(dout[9]),   .user_dataout_10(dout[10]), .user_dataout_11(dout[11]),
        .user_dataout_12(dout[12]), .user_dataout_13(dout[13]), .user_dataout_14(dout[14]),
        .user_dataout_15(dout[15]),
        .user_datain_0(din[0]),   .user_datain_1(din[1]),   .user_datain_2(din[2]),
        .user_datain_3(din[3]),   .user_datain_4(din[4]),   .user_datain_5(din[5]),
        .user_datain_6(din[6]),   .user_datain_7(din[7]),   .user_datain_8(din[8]),
        .user_datain_9(din[9]),   .user_datain_10(din[10]), .user_datain_11(din[11]),
        .user_datain_12(din[12]), .user_datain_13(din[13]), .user_datain_14(din[14]),
        .user_datain_15(din[15])
    );

    // Reference: reduce operands 1..n; SUM overflow is any excess over 2^32-1.
    function automatic void model(input logic [1:0] op, input int n,
                                  output logic [31:0] res, output logic ov);
        longint unsigned tot;
        ov = 1'b0;
        case (op)
            2'b00: begin
                tot = 0;
                for (int i = 1; i <= n; i++) tot += longint'(dout[i]);
                res = tot[31:0];
                ov  = (tot > 64'h0000_0000_FFFF_FFFF);
            end
            2'b01: begin
                res = 32'h0;
                for (int i = 1; i <= n; i++) if (dout[i] > res) res = dout[i];
            end
            2'b10: begin
                res = 32'hFFFF_FFFF;
                for (int i = 1; i <= n; i++) if (dout[i] < res) res = dout[i];
            end
            default: begin
                res = 32'h0;
                for (int i = 1; i <= n; i++) res = res ^ dout[i];
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input int n);
        logic [3:0] n4;
        n4 = 4'(n);
        dout[0] = {24'b0, n4, 2'b00, op};
        wr = 1'b1;
        cs = 16'h0001;
        tick();
        wr = 1'b0;
        cs = 16'h0000;
    endtask

    task automatic read_clear();
        rd = 1'b1;
        cs = 16'h0001;
        tick();
        rd = 1'b0;
        cs = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (din[i] !== 32'h0) $display("FAIL reset_datain_%0d: got %h expected 0", i, din[i]);
            if (din[i] !== 32'h0) errors++;
        end
        checks++;
        if (din[15] !== ID) begin
            errors++;
            $display("FAIL reset_id: got %h expected %h", din[15], ID);
        end
        rst = 1'b0;
        exp_cnt = 0;
        exp_result = 0;
    endtask

    task automatic test_sum();
        int cyc;
        dout[1] = 32'd5; dout[2] = 32'd7; dout[3] = 32'd9;
        send_cmd(2'b00, 3);
        checks++;
        if (din[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL sum_first_accept: busy got %b expected 1", din[0][0]);
        end
        cyc = 0;
        while (din[0][0] === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        exp_cnt++;
        exp_result = 32'd21;
        checks++;
        if (cyc != 4) begin errors++; $display("FAIL sum_busy_cycles: got %0d expected 4", cyc); end
        checks++;
        if (din[1] !== 32'd21) begin errors++; $display("FAIL sum_result: got %0d expected 21", din[1]); end
        checks++;
        if (din[0][1:0] !== 2'b10) begin errors++; $display("FAIL sum_status: got %b expected 10", din[0][1:0]); end
        checks++;
        if (din[2] !== 32'd1) begin errors++; $display("FAIL sum_count: got %0d expected 1", din[2]); end
    endtask

    task automatic test_minmaxxor();
        logic [1:0]  ops  [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] exps [3] = '{32'd3, 32'hFFFF_FFF0, 32'hFFFF_FFFB};
        int cyc;
        dout[1] = 32'd3; dout[2] = 32'hFFFF_FFF0; dout[3] = 32'd8;
        for (int k = 0; k < 3; k++) begin
            send_cmd(ops[k], 3);
            cyc = 0;
            while (din[0][0] === 1'b1 && cyc < 100) begin cyc++; tick(); end
            exp_cnt++;
            exp_result = exps[k];
            checks++;
            if (din[1] !== exps[k]) begin
                errors++;
                $display("FAIL mmx_result op=%b: got %h expected %h", ops[k], din[1], exps[k]);
            end
            checks++;
            if (din[3] !== {28'b0, ops[k], 2'b00}) begin
                errors++;
                $display("FAIL mmx_opcode op=%b: got %h", ops[k], din[3]);
            end
            checks++;
            if (din[2] !== exp_cnt) begin
                errors++;
                $display("FAIL mmx_count: got %0d expected %0d", din[2], exp_cnt);
            end
        end
    endtask

    task automatic test_overflow();
        int cyc;
        dout[1] = 32'hFFFF_FFFF; dout[2] = 32'd2;
        send_cmd(2'b00, 2);
        cyc = 0;
        while (din[0][0] === 1'b1 && cyc < 100) begin cyc++; tick(); end
        exp_cnt++;
        exp_result = 32'd1;
        checks++;
        if (din[1] !== 32'd1) begin errors++; $display("FAIL ovf_result: got %h expected 1", din[1]); end
        checks++;
        if (din[0][3] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", din[0][3]); end
        send_cmd(2'b11, 1);
        checks++;
        if (din[0][3] !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", din[0][3]); end
        cyc = 0;
        while (din[0][0] === 1'b1 && cyc < 100) begin cyc++; tick(); end
        exp_cnt++;
        exp_result = 32'hFFFF_FFFF;
        checks++;
        if (din[1] !== exp_result) begin errors++; $display("FAIL ovf_next_result: got %h expected %h", din[1], exp_result); end
    endtask

    task automatic test_errors();
        int bad_n [2] = '{0, 15};
        for (int k = 0; k < 2; k++) begin
            read_clear();
            send_cmd(2'b00, bad_n[k]);
            checks++;
            if (din[0][2:0] !== 3'b110) begin
                errors++;
                $display("FAIL err_status n=%0d: err/done/busy got %b expected 110", bad_n[k], din[0][2:0]);
            end
            tick();
            checks++;
            if (din[0][0] !== 1'b0) begin errors++; $display("FAIL err_busy n=%0d: got %b expected 0", bad_n[k], din[0][0]); end
            checks++;
            if (din[1] !== exp_result) begin errors++; $display("FAIL err_result n=%0d: got %h expected %h", bad_n[k], din[1], exp_result); end
            checks++;
            if (din[2] !== exp_cnt) begin errors++; $display("FAIL err_count n=%0d: got %0d expected %0d", bad_n[k], din[2], exp_cnt); end
        end
    endtask

    task automatic test_collision();
        int cyc;
        dout[1] = 32'd5; dout[2] = 32'd7; dout[3] = 32'd9;
        send_cmd(2'b00, 3);
        checks++;
        if (din[0][2] !== 1'b0) begin errors++; $display("FAIL coll_err_cleared: got %b expected 0", din[0][2]); end
        dout[2] = 32'd100;
        wr = 1'b1; cs = 16'h0004;
        tick();
        dout[0] = {24'b0, 4'd1, 2'b00, 2'b11};
        cs = 16'h0001;
        tick();
        wr = 1'b0; cs = 16'h0000;
        checks++;
        if (din[0][4] !== 1'b1) begin errors++; $display("FAIL coll_flag: got %b expected 1", din[0][4]); end
        cyc = 0;
        while (din[0][0] === 1'b1 && cyc < 100) begin cyc++; tick(); end
        exp_cnt++;
        exp_result = 32'd114;
        checks++;
        if (din[1] !== 32'd114) begin errors++; $display("FAIL coll_result: got %0d expected 114", din[1]); end
        checks++;
        if (din[3] !== 32'h0) begin errors++; $display("FAIL coll_cmd_ignored: opcode reg got %h expected 0", din[3]); end
        checks++;
        if (din[2] !== exp_cnt) begin errors++; $display("FAIL coll_count: got %0d expected %0d", din[2], exp_cnt); end
        dout[2] = 32'd7;
        send_cmd(2'b01, 1);
        checks++;
        if (din[0][4] !== 1'b0) begin errors++; $display("FAIL coll_cleared: got %b expected 0", din[0][4]); end
        cyc = 0;
        while (din[0][0] === 1'b1 && cyc < 100) begin cyc++; tick(); end
        exp_cnt++;
        exp_result = 32'd5;
    endtask

    task automatic test_read_clear();
        read_clear();
        checks++;
        if (din[0][1] !== 1'b0) begin errors++; $display("FAIL rdclr_initial: done got %b expected 0", din[0][1]); end
        dout[1] = 32'd42;
        send_cmd(2'b00, 1);
        tick();
        rd = 1'b1; cs = 16'h0001;
        tick();
        exp_cnt++;
        exp_result = 32'd42;
        checks++;
        if (din[0][1:0] !== 2'b10) begin errors++; $display("FAIL rdclr_set_wins: done/busy got %b expected 10", din[0][1:0]); end
        tick();
        rd = 1'b0; cs = 16'h0000;
        checks++;
        if (din[0][1] !== 1'b0) begin errors++; $display("FAIL rdclr_next_edge: done got %b expected 0", din[0][1]); end
        checks++;
        if (din[1] !== 32'd42) begin errors++; $display("FAIL rdclr_result: got %0d expected 42", din[1]); end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        logic [31:0] res;
        logic ov;
        for (int i = 1; i <= 5; i++) dout[i] = $urandom_range(0, 1000);
        send_cmd(2'b00, 5);
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (din[i] !== 32'h0) begin errors++; $display("FAIL midrun_reset_datain_%0d: got %h expected 0", i, din[i]); end
        end
        checks++;
        if (din[15] !== ID) begin errors++; $display("FAIL midrun_reset_id: got %h expected %h", din[15], ID); end
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        exp_result = 0;
        model(2'b00, 5, res, ov);
        send_cmd(2'b00, 5);
        cyc = 0;
        while (din[0][0] === 1'b1 && cyc < 100) begin cyc++; tick(); end
        exp_cnt++;
        exp_result = res;
        checks++;
        if (cyc != 6) begin errors++; $display("FAIL midrun_latency: got %0d expected 6", cyc); end
        checks++;
        if (din[1] !== res) begin errors++; $display("FAIL midrun_result: got %h expected %h", din[1], res); end
        checks++;
        if (din[2] !== 32'd1) begin errors++; $display("FAIL midrun_count: got %0d expected 1", din[2]); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        int          n, cyc;
        logic [31:0] res;
        logic        ov;
        for (int it = 0; it < 25; it++) begin
            op = 2'($urandom_range(0, 3));
            n  = $urandom_range(1, MAXN);
            for (int i = 1; i <= MAXN; i++)
                dout[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
            model(op, n, res, ov);
            send_cmd(op, n);
            cyc = 0;
            while (din[0][0] === 1'b1 && cyc < 100) begin
                checks++;
                if (din[1] !== exp_result) begin
                    errors++;
                    $display("FAIL rand_result_stable it=%0d: got %h expected %h", it, din[1], exp_result);
                end
                cyc++;
                tick();
            end
            exp_cnt++;
            exp_result = res;
            checks++;
            if (cyc != n + 1) begin errors++; $display("FAIL rand_latency it=%0d: got %0d expected %0d", it, cyc, n + 1); end
            checks++;
            if (din[1] !== res) begin errors++; $display("FAIL rand_result it=%0d op=%b n=%0d: got %h expected %h", it, op, n, din[1], res); end
            checks++;
            if (din[0][3] !== ov) begin errors++; $display("FAIL rand_ovf it=%0d: got %b expected %b", it, din[0][3], ov); end
            checks++;
            if (din[2] !== exp_cnt) begin errors++; $display("FAIL rand_count it=%0d: got %0d expected %0d", it, din[2], exp_cnt); end
            checks++;
            if (din[0][15:8] !== exp_cnt[7:0]) begin errors++; $display("FAIL rand_count_byte it=%0d: got %h expected %h", it, din[0][15:8], exp_cnt[7:0]); end
            checks++;
            if (din[3] !== {28'b0, op, 2'b00}) begin errors++; $display("FAIL rand_opcode it=%0d: got %h", it, din[3]); end
            checks++;
            if (din[0][1] !== 1'b1) begin errors++; $display("FAIL rand_done it=%0d: got %b expected 1", it, din[0][1]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wr  = 1'b0;
        rd  = 1'b0;
        cs  = 16'h0;
        for (int i = 0; i < 16; i++) dout[i] = 32'h0;
        #1;
        test_reset();
        test_sum();
        test_minmaxxor();
        test_overflow();
        test_errors();
        test_collision();
        test_read_clear();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
